// File: rtl/uart_echo_tester.sv
// uart_echo_tester
//   Built-in self-test initiator for a UART loopback path. Sends the byte
//   sequence SEED, SEED+1, ... (8-bit wrap) through uart_tx, and checks each
//   byte echoed back through uart_rx. It reports pass/fail, an error count
//   and the last mismatching pair.
//
// Parameters
//   NUM_BYTES      bytes per test (1..65535)
//   SEED           first byte value
//   TIMEOUT_CYCLES maximum clk cycles to wait for each echo (>= 2)
//
// Ports
//   clk, nrst      clock; synchronous active-low reset
//   run            rising edge starts a test (ignored while busy)
//   tx_data        byte presented to uart_tx
//   tx_start       start request to uart_tx
//   tx_busy        uart_tx busy
//   rx_data        byte from uart_rx, valid with rx_done
//   rx_done        uart_rx done (pulse or level; edge-detected here)
//   busy           test in progress
//   done           test finished; held until the next start
//   pass           valid while done; 1 = zero errors
//   err_count      mismatches + timeouts + overruns, saturating
//   timeout_flag   sticky: at least one echo timed out in this test
//   last_expected  expected byte of the most recent error
//   last_received  received byte of the most recent error (00 on timeout)
module uart_echo_tester #(
  parameter int unsigned NUM_BYTES      = 256,
  parameter logic [7:0]  SEED           = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        run,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        timeout_flag,
  output logic [7:0]  last_expected,
  output logic [7:0]  last_received
);

  typedef enum logic [2:0] {
    IDLE, SEND, TXWAIT, WAIT_RX, CHECK, ADVANCE, DONE
  } state_t;

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]    IDX_LAST = 16'(NUM_BYTES - 1);

  state_t           state, state_next;
  logic [15:0]      idx, idx_next;
  logic             pending, pending_next;
  logic [7:0]       rx_hold, rx_hold_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             run_last, rx_done_last;

  logic [7:0]  tx_data_next;
  logic        tx_start_next, busy_next, done_next, pass_next, timeout_flag_next;
  logic [15:0] err_count_next;
  logic [7:0]  last_expected_next, last_received_next;

  logic        run_edge, rx_edge, active, overrun;
  logic        fsm_err, clear_err, pending_clear;
  logic [7:0]  expected;
  logic [1:0]  inc;
  logic [16:0] err_sum;

  assign active   = (state != IDLE) && (state != DONE);
  assign run_edge = run & ~run_last;
  assign rx_edge  = rx_done & ~rx_done_last & active;
  assign overrun  = rx_edge & pending;
  assign expected = SEED + idx[7:0];

  always_comb begin
    state_next         = state;
    idx_next           = idx;
    pending_next       = pending;
    rx_hold_next       = rx_hold;
    cnt_next           = cnt;
    tx_data_next       = tx_data;
    tx_start_next      = tx_start;
    done_next          = done;
    pass_next          = pass;
    timeout_flag_next  = timeout_flag;
    last_expected_next = last_expected;
    last_received_next = last_received;
    fsm_err            = 1'b0;
    clear_err          = 1'b0;
    pending_clear      = 1'b0;
    inc                = 2'd0;
    err_sum            = 17'd0;
    err_count_next     = err_count;

    case (state)
      IDLE, DONE: begin
        if (run_edge) begin
          state_next         = SEND;
          idx_next           = 16'd0;
          tx_data_next       = SEED;
          tx_start_next      = 1'b1;
          done_next          = 1'b0;
          pass_next          = 1'b0;
          timeout_flag_next  = 1'b0;
          last_expected_next = 8'h00;
          last_received_next = 8'h00;
          clear_err          = 1'b1;
          // A capture that landed during the final CHECK/ADVANCE of the
          // previous test must not leak into the new one.
          pending_clear      = 1'b1;
        end
      end
      SEND: begin
        if (tx_busy) begin
          tx_start_next = 1'b0;
          state_next    = TXWAIT;
        end
      end
      TXWAIT: begin
        if (!tx_busy) begin
          state_next = WAIT_RX;
          cnt_next   = '0;
        end
      end
      WAIT_RX: begin
        if (pending) begin
          state_next = CHECK;
        end else if (cnt == CNT_LAST) begin
          fsm_err            = 1'b1;
          timeout_flag_next  = 1'b1;
          last_expected_next = expected;
          last_received_next = 8'h00;
          state_next         = ADVANCE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      CHECK: begin
        pending_clear = 1'b1;
        if (rx_hold != expected) begin
          fsm_err            = 1'b1;
          last_expected_next = expected;
          last_received_next = rx_hold;
        end
        state_next = ADVANCE;
      end
      ADVANCE: begin
        if (idx == IDX_LAST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          idx_next      = idx + 16'd1;
          tx_data_next  = expected + 8'd1;
          tx_start_next = 1'b1;
          state_next    = SEND;
        end
      end
      default: state_next = IDLE;
    endcase

    // Echo capture; a new edge wins over a CHECK clearing pending so the
    // newer byte is still examined.
    if (rx_edge) begin
      pending_next = 1'b1;
      rx_hold_next = rx_data;
    end else if (pending_clear) begin
      pending_next = 1'b0;
    end

    // Overrun and FSM errors may coincide: add up to 2, saturating.
    inc     = {1'b0, fsm_err} + {1'b0, overrun};
    err_sum = {1'b0, err_count} + {15'd0, inc};
    if (clear_err)
      err_count_next = 16'd0;
    else if (err_sum[16])
      err_count_next = 16'hFFFF;
    else
      err_count_next = err_sum[15:0];

    // pass must account for an overrun landing in the final ADVANCE cycle.
    if (state == ADVANCE && idx == IDX_LAST)
      pass_next = (err_count_next == 16'd0);

    busy_next = (state_next != IDLE) && (state_next != DONE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= IDLE;
      idx           <= 16'd0;
      pending       <= 1'b0;
      rx_hold       <= 8'h00;
      cnt           <= '0;
      // Start high so levels already present at reset are not seen as edges.
      run_last      <= 1'b1;
      rx_done_last  <= 1'b1;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 16'd0;
      timeout_flag  <= 1'b0;
      last_expected <= 8'h00;
      last_received <= 8'h00;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      pending       <= pending_next;
      rx_hold       <= rx_hold_next;
      cnt           <= cnt_next;
      run_last      <= run;
      rx_done_last  <= rx_done;
      tx_data       <= tx_data_next;
      tx_start      <= tx_start_next;
      busy          <= busy_next;
      done          <= done_next;
      pass          <= pass_next;
      err_count     <= err_count_next;
      timeout_flag  <= timeout_flag_next;
      last_expected <= last_expected_next;
      last_received <= last_received_next;
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// tb_uart_echo_tester
//   Two tester instances (SEED A5 and SEED FE, 4 bytes, 1000-cycle timeout)
//   each driven by a behavioural uart_tx + loopback + uart_rx model that can
//   drop or corrupt one chosen frame. Expected byte sequences are queued when
//   a run is started and compared against the bytes the model saw sent.
module tb_uart_echo_tester;

  localparam int NUM      = 4;
  localparam int TMO      = 1000;
  localparam int TX_LEN   = 10;
  localparam int ECHO_DLY = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        run           [2];
  logic [7:0]  tx_data       [2];
  logic        tx_start      [2];
  logic        tx_busy       [2];
  logic [7:0]  rx_data       [2];
  logic        rx_done       [2];
  logic        busy          [2];
  logic        done          [2];
  logic        pass          [2];
  logic [15:0] err_count     [2];
  logic        timeout_flag  [2];
  logic [7:0]  last_expected [2];
  logic [7:0]  last_received [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         nsent       [2] = '{0, 0};
  int         drop_idx    [2] = '{-1, -1};
  int         corrupt_idx [2] = '{-1, -1};
  int         fall_cyc    [2][8];
  logic [7:0] sent_mem    [2][16];
  logic [7:0] exp_q [$];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam logic [7:0] LANE_SEED = (gi == 0) ? 8'hA5 : 8'hFE;

    uart_echo_tester #(
      .NUM_BYTES(NUM), .SEED(LANE_SEED), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .clk(clk), .nrst(nrst), .run(run[gi]),
      .tx_data(tx_data[gi]), .tx_start(tx_start[gi]), .tx_busy(tx_busy[gi]),
      .rx_data(rx_data[gi]), .rx_done(rx_done[gi]),
      .busy(busy[gi]), .done(done[gi]), .pass(pass[gi]),
      .err_count(err_count[gi]), .timeout_flag(timeout_flag[gi]),
      .last_expected(last_expected[gi]), .last_received(last_received[gi])
    );

    // Behavioural uart_tx -> loopback -> uart_rx.
    initial begin : model
      logic [7:0] b;
      int k;
      tx_busy[gi] = 1'b0;
      rx_done[gi] = 1'b0;
      rx_data[gi] = 8'h00;
      forever begin
        @(posedge clk);
        #1;
        if (tx_start[gi] === 1'b1) begin
          b = tx_data[gi];
          k = nsent[gi];
          nsent[gi] = nsent[gi] + 1;
          if (k < 16) sent_mem[gi][k] = b;
          tx_busy[gi] = 1'b1;
          repeat (TX_LEN) @(posedge clk);
          #1 tx_busy[gi] = 1'b0;
          if (k < 8) fall_cyc[gi][k] = cyc;
          if (k != drop_idx[gi]) begin
            repeat (ECHO_DLY) @(posedge clk);
            #1;
            rx_data[gi] = (k == corrupt_idx[gi]) ? 8'h00 : b;
            rx_done[gi] = 1'b1;
            @(posedge clk);
            #1 rx_done[gi] = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] seed_of(input int gi);
    return (gi == 0) ? 8'hA5 : 8'hFE;
  endfunction

  task automatic push_expected(input int gi);
    exp_q.delete();
    for (int i = 0; i < NUM; i++) exp_q.push_back(8'(seed_of(gi) + 8'(i)));
    nsent[gi] = 0;
  endtask

  task automatic start_run(input int gi);
    push_expected(gi);
    @(negedge clk); run[gi] = 1'b1;
    @(negedge clk); run[gi] = 1'b0;
  endtask

  task automatic wait_done(input int gi, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done[gi] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] e;
    nrst = 1'b0; run[0] = 1'b1; run[1] = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({tx_start[0], busy[0], done[0], pass[0], timeout_flag[0], err_count[0],
         tx_data[0], last_expected[0], last_received[0]} !== 44'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got start=%b busy=%b done=%b pass=%b tf=%b err=%h txd=%h le=%h lr=%h, required all 0",
               tx_start[0], busy[0], done[0], pass[0], timeout_flag[0], err_count[0],
               tx_data[0], last_expected[0], last_received[0]);
    end
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tx_start[0] !== 1'b0 || busy[0] !== 1'b0 || tx_start[1] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL run_held_through_reset: got tx_start=%b/%b busy=%b, required 0/0/0",
               tx_start[0], tx_start[1], busy[0]);
    end
    run[0] = 1'b0; run[1] = 1'b0;
    push_expected(0);
    @(negedge clk);
    tests++;
    if (tx_start[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_before_edge: got tx_start=%b, required 0", tx_start[0]);
    end
    run[0] = 1'b1;
    @(negedge clk);
    run[0] = 1'b0;
    tests++;
    if (tx_start[0] !== 1'b1 || tx_data[0] !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL first_start: got tx_start=%b tx_data=%h, required 1 / a5",
               tx_start[0], tx_data[0]);
    end
    wait_done(0, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL reset_run_done: got done=%b, required 1 within bound", done[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    $display("[TB] reset: run held ignored, first start tx_data=%h", 8'hA5);
  endtask

  task automatic test_perfect_echo();
    bit ok;
    logic [7:0] e;
    start_run(0);
    wait_done(0, ok);
    tests++;
    if (!ok || pass[0] !== 1'b1 || err_count[0] !== 16'd0 || timeout_flag[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL perfect_result: got done=%b pass=%b err=%0d tf=%b busy=%b, required 1 1 0 0 0",
               done[0], pass[0], err_count[0], timeout_flag[0], busy[0]);
    end
    tests++;
    if (nsent[0] != NUM) begin
      fails++;
      $display("[TB] FAIL perfect_count: got %0d bytes sent, required %0d", nsent[0], NUM);
    end
    for (int k = 0; k < NUM && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (sent_mem[0][k] !== e) begin
        fails++;
        $display("[TB] FAIL perfect_byte%0d: got %h, required %h", k, sent_mem[0][k], e);
      end
    end
    $display("[TB] perfect echo: err=%0d pass=%b", err_count[0], pass[0]);
  endtask

  task automatic test_corruption();
    bit ok;
    logic [7:0] e;
    corrupt_idx[0] = 2;
    start_run(0);
    wait_done(0, ok);
    corrupt_idx[0] = -1;
    tests++;
    if (!ok || pass[0] !== 1'b0 || err_count[0] !== 16'd1 || timeout_flag[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL corrupt_result: got done=%b pass=%b err=%0d tf=%b, required 1 0 1 0",
               done[0], pass[0], err_count[0], timeout_flag[0]);
    end
    tests++;
    if (last_expected[0] !== 8'hA7 || last_received[0] !== 8'h00) begin
      fails++;
      $display("[TB] FAIL corrupt_pair: got exp=%h rcv=%h, required a7 / 00",
               last_expected[0], last_received[0]);
    end
    for (int k = 0; k < NUM && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (sent_mem[0][k] !== e) begin
        fails++;
        $display("[TB] FAIL corrupt_byte%0d: got %h, required %h", k, sent_mem[0][k], e);
      end
    end
    $display("[TB] corruption: err=%0d last=%h/%h", err_count[0], last_expected[0], last_received[0]);
  endtask

  task automatic test_timeout();
    bit ok;
    int t;
    logic [7:0] e;
    drop_idx[0] = 0;
    start_run(0);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (timeout_flag[0] === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    tests++;
    if (!ok || (t - fall_cyc[0][0]) != TMO + 1) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got flag=%b after %0d cycles, required 1 after %0d",
               timeout_flag[0], t - fall_cyc[0][0], TMO + 1);
    end
    tests++;
    if (err_count[0] !== 16'd1) begin
      fails++;
      $display("[TB] FAIL timeout_err_at_flag: got %0d, required 1", err_count[0]);
    end
    wait_done(0, ok);
    drop_idx[0] = -1;
    tests++;
    if (!ok || pass[0] !== 1'b0 || err_count[0] !== 16'd1 || timeout_flag[0] !== 1'b1 ||
        last_expected[0] !== 8'hA5 || last_received[0] !== 8'h00) begin
      fails++;
      $display("[TB] FAIL timeout_result: got done=%b pass=%b err=%0d tf=%b pair=%h/%h, required 1 0 1 1 a5/00",
               done[0], pass[0], err_count[0], timeout_flag[0], last_expected[0], last_received[0]);
    end
    for (int k = 0; k < NUM && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (sent_mem[0][k] !== e) begin
        fails++;
        $display("[TB] FAIL timeout_byte%0d: got %h, required %h", k, sent_mem[0][k], e);
      end
    end
    $display("[TB] timeout: flag after %0d cycles, err=%0d", t - fall_cyc[0][0], err_count[0]);
  endtask

  task automatic test_wrap_restart();
    bit ok;
    logic [7:0] e;
    corrupt_idx[1] = 0;
    start_run(1);
    wait_done(1, ok);
    corrupt_idx[1] = -1;
    tests++;
    if (!ok || pass[1] !== 1'b0 || err_count[1] !== 16'd1 || last_expected[1] !== 8'hFE) begin
      fails++;
      $display("[TB] FAIL wrap_first_result: got done=%b pass=%b err=%0d le=%h, required 1 0 1 fe",
               done[1], pass[1], err_count[1], last_expected[1]);
    end
    for (int k = 0; k < NUM && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (sent_mem[1][k] !== e) begin
        fails++;
        $display("[TB] FAIL wrap_byte%0d: got %h, required %h", k, sent_mem[1][k], e);
      end
    end
    start_run(1);
    tests++;
    if (err_count[1] !== 16'd0 || done[1] !== 1'b0 || pass[1] !== 1'b0 || busy[1] !== 1'b1 ||
        last_expected[1] !== 8'h00 || last_received[1] !== 8'h00 || tx_data[1] !== 8'hFE) begin
      fails++;
      $display("[TB] FAIL restart_clear: got err=%0d done=%b pass=%b busy=%b pair=%h/%h txd=%h, required 0 0 0 1 00/00 fe",
               err_count[1], done[1], pass[1], busy[1], last_expected[1], last_received[1], tx_data[1]);
    end
    repeat (30) @(negedge clk);
    run[1] = 1'b1;
    @(negedge clk);
    run[1] = 1'b0;
    wait_done(1, ok);
    tests++;
    if (!ok || pass[1] !== 1'b1 || err_count[1] !== 16'd0 || nsent[1] != NUM) begin
      fails++;
      $display("[TB] FAIL busy_edge_ignored: got done=%b pass=%b err=%0d sent=%0d, required 1 1 0 %0d",
               done[1], pass[1], err_count[1], nsent[1], NUM);
    end
    for (int k = 0; k < NUM && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (sent_mem[1][k] !== e) begin
        fails++;
        $display("[TB] FAIL rerun_byte%0d: got %h, required %h", k, sent_mem[1][k], e);
      end
    end
    $display("[TB] wrap/restart: bytes %h %h %h %h, pass=%b",
             sent_mem[1][0], sent_mem[1][1], sent_mem[1][2], sent_mem[1][3], pass[1]);
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [7:0] e;
    start_run(0);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (nsent[0] == 3 && tx_busy[0] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    tests++;
    if (!ok || busy[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reach_wait_rx: got reached=%b busy=%b, required 1 1", ok, busy[0]);
    end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tests++;
    if ({tx_start[0], busy[0], done[0], pass[0], timeout_flag[0], err_count[0],
         tx_data[0], last_expected[0], last_received[0]} !== 44'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs: got start=%b busy=%b done=%b err=%0d txd=%h, required all 0",
               tx_start[0], busy[0], done[0], err_count[0], tx_data[0]);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || tx_start[0] !== 1'b0 || err_count[0] !== 16'd0) begin
      fails++;
      $display("[TB] FAIL late_echo_ignored: got busy=%b done=%b start=%b err=%0d, required 0 0 0 0",
               busy[0], done[0], tx_start[0], err_count[0]);
    end
    start_run(0);
    wait_done(0, ok);
    tests++;
    if (!ok || pass[0] !== 1'b1 || err_count[0] !== 16'd0) begin
      fails++;
      $display("[TB] FAIL post_reset_run: got done=%b pass=%b err=%0d, required 1 1 0",
               done[0], pass[0], err_count[0]);
    end
    for (int k = 0; k < NUM && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (sent_mem[0][k] !== e) begin
        fails++;
        $display("[TB] FAIL post_reset_byte%0d: got %h, required %h", k, sent_mem[0][k], e);
      end
    end
    $display("[TB] mid-test reset: outputs cleared, rerun pass=%b", pass[0]);
  endtask

  initial begin
    nrst = 1'b0;
    run[0] = 1'b0;
    run[1] = 1'b0;
    test_reset();
    test_perfect_echo();
    test_corruption();
    test_timeout();
    test_wrap_restart();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
